// File: rtl/array_16_ctrl.sv
// Access controller for the single-port 1024 x 7776 array macro: zeroing sweep after reset/flush,
// then read/write arbitration with a starvation guard for reads and a 1-cycle read response strobe.
module array_16_ctrl #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned DATA_W       = 7776,
   parameter int unsigned MASK_W       = 16,
   parameter int unsigned STARVE_LIMIT = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush_req,
   output logic              init_done,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rresp_valid,
   output logic [DATA_W-1:0] rresp_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [MASK_W-1:0] wr_mask,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic              RW0_en,
   output logic              RW0_wmode,
   output logic [DATA_W-1:0] RW0_wdata,
   output logic [MASK_W-1:0] RW0_wmask,
   input  logic [DATA_W-1:0] RW0_rdata
);

   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

   localparam logic [0:0] StInit = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
   logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
   logic               rresp_valid_q;
   logic               run, starved, rd_gnt, wr_gnt;

   assign run     = (state_q == StRun);
   assign starved = (starve_cnt_q == StarveW'(STARVE_LIMIT));

   // Writes win by default; a read that has waited STARVE_LIMIT cycles takes the port.
   assign wr_gnt = run && wr_valid && (!rd_valid || !starved);
   assign rd_gnt = run && rd_valid && (!wr_valid || starved);

   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      starve_cnt_d = starve_cnt_q;
      if (!run) begin
         starve_cnt_d = '0;
         if (flush_req) begin
            init_cnt_d = '0;
         end else if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
            init_cnt_d = '0;
            state_d    = StRun;
         end else begin
            init_cnt_d = init_cnt_q + ADDR_W'(1);
         end
      end else if (flush_req) begin
         state_d      = StInit;
         init_cnt_d   = '0;
         starve_cnt_d = '0;
      end else if (rd_gnt) begin
         starve_cnt_d = '0;
      end else if (rd_valid && !starved) begin
         starve_cnt_d = starve_cnt_q + StarveW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StInit;
         init_cnt_q    <= '0;
         starve_cnt_q  <= '0;
         rresp_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         init_cnt_q    <= init_cnt_d;
         starve_cnt_q  <= starve_cnt_d;
         rresp_valid_q <= rd_gnt;
      end
   end

   // The sweep drive is gated by reset so the macro sees an idle port while reset is held.
   always_comb begin
      RW0_en    = 1'b0;
      RW0_wmode = 1'b0;
      RW0_addr  = '0;
      RW0_wdata = '0;
      RW0_wmask = '0;
      if (reset) begin
         RW0_en = 1'b0;
      end else if (!run) begin
         RW0_en    = 1'b1;
         RW0_wmode = 1'b1;
         RW0_addr  = init_cnt_q;
         RW0_wmask = '1;
      end else if (wr_gnt) begin
         RW0_en    = 1'b1;
         RW0_wmode = 1'b1;
         RW0_addr  = wr_addr;
         RW0_wdata = wr_data;
         RW0_wmask = wr_mask;
      end else if (rd_gnt) begin
         RW0_en   = 1'b1;
         RW0_addr = rd_addr;
      end
   end

   assign init_done   = run;
   assign rd_ready    = rd_gnt;
   assign wr_ready    = wr_gnt;
   assign rresp_valid = rresp_valid_q;
   assign rresp_data  = reset ? '0 : RW0_rdata;

endmodule
